vga_timing_ctrl: RTL and testbench
==================================

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameters V_VISIBLE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33, with the same meanings in lines.
REQ-006 SHALL have port clk, input, 1, the single clock, driven from the global-buffered external oscillator.
REQ-007 SHALL have port nrst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port pix_en, input, 1, pixel-clock enable from the divider; all timing advances only on clk edges with pix_en=1.
REQ-009 SHALL have port hsync_n, output, 1, horizontal sync, active low.
REQ-010 SHALL have port vsync_n, output, 1, vertical sync, active low.
REQ-011 SHALL have port vis, output, 1, high while the current pixel is inside the visible area.
REQ-012 SHALL have port x, output, 10, pixel column; valid when vis=1.
REQ-013 SHALL have port y, output, 10, line number; valid when vis=1.
REQ-014 SHALL have port frame_start, output, 1, one-clk pulse on the pix_en cycle entering pixel (0,0).
REQ-015 SHALL have ports irq (output, 1) and irq_ack (input, 1), present only when VSYNC_IRQ_EN is defined.

Function
REQ-016 SHALL run a horizontal FSM with states H_VIS, H_FRONT, H_SYNCP, H_BACK in that cyclic order, each lasting its parameter count of pix_en cycles.
REQ-017 SHALL run a vertical FSM with states V_VIS, V_FRONT, V_SYNCP, V_BACK, advancing one line only on the pix_en cycle in which H_BACK finishes.
REQ-018 SHALL use one per-FSM down/up counter, reloaded at each state transition; no counter shall exceed 10 bits, and wrap at the end of H_BACK/V_BACK returns to H_VIS/V_VIS with count 0.
REQ-019 SHALL drive hsync_n=0 only in H_SYNCP and vsync_n=0 only in V_SYNCP.
REQ-020 SHALL assert vis only when both FSMs are in their VIS states.
REQ-021 SHALL register all outputs; outputs reflect the pixel entered on the previous qualifying clk edge (latency 1 clk).
REQ-022 SHALL hold all state and outputs unchanged on cycles with pix_en=0, except that frame_start deasserts after one clk.
REQ-023 SHALL give one line H_VISIBLE+H_FP+H_SYNC+H_BP pixels and one frame V_VISIBLE+V_FP+V_SYNC+V_BP lines exactly.

Reset
REQ-024 SHALL, while nrst=0, force both FSMs to VIS with counts 0, hsync_n=1, vsync_n=1, vis=0, x=0, y=0, frame_start=0, irq=0.
REQ-025 SHALL, on the first pix_en cycle after nrst deasserts, present pixel (0,0) with vis=1 and frame_start=1; reset mid-frame abandons the frame without partial sync pulses.

Configuration
REQ-026 SHALL, when VGA_TIMING_VSYNC_IRQ_EN is defined, set irq on the pix_en cycle entering V_FRONT line 0 and hold it until a clk with irq_ack=1; simultaneous set and ack leaves irq=1.
REQ-027 SHALL, when VGA_TIMING_VSYNC_IRQ_EN is undefined, omit irq, irq_ack and their logic entirely.

Structure
REQ-028 SHALL take the FSM state encodings and default timing constants from a shared package vga_timing_pkg.
REQ-029 SHALL implement each axis with one sub-module vga_axis_fsm, instantiated twice (horizontal advanced by pix_en, vertical by the horizontal wrap).

Verification
REQ-030 Bench SHALL use H=8/2/3/2, V=4/1/2/1, pix_en tied 1 -> line period 15 clk, frame 120 clk, hsync_n low exactly 3 clk per line, vsync_n low exactly 30 clk.
REQ-031 Bench SHALL toggle pix_en every other clk -> all periods double; x,y step only on pix_en=1; frame_start width exactly 1 clk.
REQ-032 Bench SHALL check vis=1 for exactly 32 of 120 clk per frame with x=0..7, y=0..3 in raster order.
REQ-033 Bench SHALL assert nrst=0 mid-sync for 3 clk -> outputs at reset values immediately; after release frame_start=1 and x=y=0.
REQ-034 Bench SHALL, with VGA_TIMING_VSYNC_IRQ_EN, check irq rises at entry to line 4, stays high until irq_ack, and stays high when irq_ack coincides with the next set.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared state encoding, counter width and default 640x480@60 timing for the VGA timing controller.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  typedef enum logic [1:0] {
    ST_VIS   = 2'd0,
    ST_FRONT = 2'd1,
    ST_SYNCP = 2'd2,
    ST_BACK  = 2'd3
  } axis_state_e;

  function automatic axis_state_e next_state(input axis_state_e s);
    case (s)
      ST_VIS:   return ST_FRONT;
      ST_FRONT: return ST_SYNCP;
      ST_SYNCP: return ST_BACK;
      default:  return ST_VIS;
    endcase
  endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// One timing axis: VIS -> FRONT -> SYNCP -> BACK, with a count that restarts at 0 in every state.
module vga_axis_fsm
  import vga_timing_pkg::*;
#(
  parameter int VIS_LEN  = DEF_H_VISIBLE,
  parameter int FP_LEN   = DEF_H_FP,
  parameter int SYNC_LEN = DEF_H_SYNC,
  parameter int BP_LEN   = DEF_H_BP
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             adv,
  output axis_state_e      state,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] VIS_LAST  = CNT_W'(VIS_LEN - 1);
  localparam logic [CNT_W-1:0] FP_LAST   = CNT_W'(FP_LEN - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] BP_LAST   = CNT_W'(BP_LEN - 1);

  axis_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last;

  always_comb begin
    case (state_q)
      ST_VIS:   last = VIS_LAST;
      ST_FRONT: last = FP_LAST;
      ST_SYNCP: last = SYNC_LAST;
      default:  last = BP_LAST;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (adv) begin
      if (cnt_q == last) begin
        state_d = next_state(state_q);
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_VIS;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;
  assign cnt   = cnt_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA sync/visible-area generator; the axis FSMs hold the next pixel, outputs show the pixel just entered.
// Optional vsync interrupt (irq/irq_ack) enabled by defining VGA_TIMING_VSYNC_IRQ_EN.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       pix_en,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       vis,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start
`ifdef VGA_TIMING_VSYNC_IRQ_EN
  ,
  output logic       irq,
  input  logic       irq_ack
`endif
);

  localparam logic [CNT_W-1:0] H_BP_LAST = CNT_W'(H_BP - 1);

  axis_state_e      h_state, v_state;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap;

  assign h_wrap = pix_en && (h_state == ST_BACK) && (h_cnt == H_BP_LAST);

  vga_axis_fsm #(
    .VIS_LEN (H_VISIBLE),
    .FP_LEN  (H_FP),
    .SYNC_LEN(H_SYNC),
    .BP_LEN  (H_BP)
  ) u_h_axis (
    .clk  (clk),
    .nrst (nrst),
    .adv  (pix_en),
    .state(h_state),
    .cnt  (h_cnt)
  );

  vga_axis_fsm #(
    .VIS_LEN (V_VISIBLE),
    .FP_LEN  (V_FP),
    .SYNC_LEN(V_SYNC),
    .BP_LEN  (V_BP)
  ) u_v_axis (
    .clk  (clk),
    .nrst (nrst),
    .adv  (h_wrap),
    .state(v_state),
    .cnt  (v_cnt)
  );

  logic       hsync_n_q, hsync_n_d;
  logic       vsync_n_q, vsync_n_d;
  logic       vis_q, vis_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       frame_start_q, frame_start_d;
  logic       at_origin;

  assign at_origin = (h_state == ST_VIS) && (v_state == ST_VIS) &&
                     (h_cnt == '0) && (v_cnt == '0);

  always_comb begin
    hsync_n_d     = hsync_n_q;
    vsync_n_d     = vsync_n_q;
    vis_d         = vis_q;
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    if (pix_en) begin
      hsync_n_d     = (h_state != ST_SYNCP);
      vsync_n_d     = (v_state != ST_SYNCP);
      vis_d         = (h_state == ST_VIS) && (v_state == ST_VIS);
      x_d           = (h_state == ST_VIS) ? h_cnt : '0;
      y_d           = (v_state == ST_VIS) ? v_cnt : '0;
      frame_start_d = at_origin;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      vis_q         <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      vis_q         <= vis_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign vis         = vis_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_VSYNC_IRQ_EN
  logic irq_q, irq_d;

  // A new set beats a coincident acknowledge so no vsync event is lost.
  always_comb begin
    irq_d = irq_q;
    if (irq_ack) irq_d = 1'b0;
    if (pix_en && (v_state == ST_FRONT) && (v_cnt == '0) &&
        (h_state == ST_VIS) && (h_cnt == '0)) irq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl with an 8/2/3/2 x 4/1/2/1 raster; irq checks need VGA_TIMING_VSYNC_IRQ_EN.
module tb_vga_timing_ctrl;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int LINE  = HV + HF + HS + HB;
  localparam int FRAME = LINE * (VV + VF + VS + VB);

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       pix_en = 1'b0;
  logic       hsync_n, vsync_n, vis, frame_start;
  logic [9:0] x, y;
`ifdef VGA_TIMING_VSYNC_IRQ_EN
  logic       irq;
  logic       irq_ack = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .pix_en     (pix_en),
    .hsync_n    (hsync_n),
    .vsync_n    (vsync_n),
    .vis        (vis),
    .x          (x),
    .y          (y),
    .frame_start(frame_start)
`ifdef VGA_TIMING_VSYNC_IRQ_EN
    ,
    .irq        (irq),
    .irq_ack    (irq_ack)
`endif
  );

  // Model: a linear pixel index within the frame, advanced by qualifying edges.
  int cur = 0;
  int nxt = 0;
  bit started = 1'b0;
  bit fs_e = 1'b0;
  bit irq_e = 1'b0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cur     <= 0;
      nxt     <= 0;
      started <= 1'b0;
      fs_e    <= 1'b0;
      irq_e   <= 1'b0;
    end else begin
      fs_e <= pix_en && (nxt == 0);
      if (pix_en) begin
        cur     <= nxt;
        nxt     <= (nxt + 1) % FRAME;
        started <= 1'b1;
      end
`ifdef VGA_TIMING_VSYNC_IRQ_EN
      if (pix_en && (nxt == VV * LINE)) irq_e <= 1'b1;
      else if (irq_ack)                 irq_e <= 1'b0;
`endif
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      if (!started) begin
        chk("m_hsync_rst", 32'(hsync_n), 1);
        chk("m_vsync_rst", 32'(vsync_n), 1);
        chk("m_vis_rst", 32'(vis), 0);
        chk("m_x_rst", 32'(x), 0);
        chk("m_y_rst", 32'(y), 0);
      end else begin
        int hx, vy;
        bit ev;
        hx = cur % LINE;
        vy = cur / LINE;
        ev = (hx < HV) && (vy < VV);
        chk("m_vis", 32'(vis), 32'(ev));
        chk("m_hsync_n", 32'(hsync_n), 32'(!((hx >= HV + HF) && (hx < HV + HF + HS))));
        chk("m_vsync_n", 32'(vsync_n), 32'(!((vy >= VV + VF) && (vy < VV + VF + VS))));
        if (ev) begin
          chk("m_x", 32'(x), 32'(hx));
          chk("m_y", 32'(y), 32'(vy));
        end
      end
      chk("m_frame_start", 32'(frame_start), 32'(fs_e));
`ifdef VGA_TIMING_VSYNC_IRQ_EN
      chk("m_irq", 32'(irq), 32'(irq_e));
`endif
    end
  end

  initial begin
    int hsl, vsl, vc, fsc, bad;
    bit found, f;
    #1 nrst = 1'b0;
    pix_en = 1'b1;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hsync_n", 32'(hsync_n), 1);
    chk("rst_vis", 32'(vis), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    #2 nrst = 1'b1;

    // Continuous pix_en: one full frame.
    hsl = 0; vsl = 0; vc = 0; fsc = 0; bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("first_fs", 32'(frame_start), 1);
        chk("first_vis", 32'(vis), 1);
      end
      if (i < LINE && !hsync_n) hsl++;
      if (!vsync_n) vsl++;
      if (frame_start) fsc++;
      if (vis) begin
        if (int'(x) != vc % HV || int'(y) != vc / HV) bad++;
        vc++;
      end
    end
    chk("hsync_low_line0", hsl, 3);
    chk("vsync_low_frame", vsl, 30);
    chk("vis_count_frame", vc, 32);
    chk("fs_count_frame", fsc, 1);
    chk("raster_order_errs", bad, 0);
    @(negedge clk);
    chk("frame_period_120", 32'(frame_start), 1);

    // pix_en every other clk.
    pix_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 4 * FRAME && !found; i++) begin
      @(negedge clk);
      f = frame_start;
      pix_en = ~pix_en;
      if (f) found = 1'b1;
    end
    chk("half_rate_fs_found", 32'(found), 1);
    hsl = 0; vsl = 0; vc = 1; fsc = 1;
    for (int j = 1; j < 2 * FRAME; j++) begin
      @(negedge clk);
      if (!hsync_n) hsl++;
      if (!vsync_n) vsl++;
      if (frame_start) fsc++;
      if (vis) vc++;
      pix_en = ~pix_en;
    end
    chk("half_hsync_low", hsl, 48);
    chk("half_vsync_low", vsl, 60);
    chk("half_vis_count", vc, 64);
    chk("half_fs_width", fsc, 1);
    @(negedge clk);
    chk("frame_period_240", 32'(frame_start), 1);

    // Reset in the middle of an hsync pulse.
    pix_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2 * LINE && !found; i++) begin
      @(negedge clk);
      if (!hsync_n) found = 1'b1;
    end
    chk("hsync_seen", 32'(found), 1);
    #2 nrst = 1'b0;
    #1;
    chk("async_rst_hsync_n", 32'(hsync_n), 1);
    chk("async_rst_vsync_n", 32'(vsync_n), 1);
    chk("async_rst_vis", 32'(vis), 0);
    chk("async_rst_x", 32'(x), 0);
    chk("async_rst_y", 32'(y), 0);
    chk("async_rst_fs", 32'(frame_start), 0);
    repeat (3) @(negedge clk);
    #2 nrst = 1'b1;
    @(negedge clk);
    chk("post_rst_fs", 32'(frame_start), 1);
    chk("post_rst_x", 32'(x), 0);
    chk("post_rst_y", 32'(y), 0);
    chk("post_rst_vis", 32'(vis), 1);

`ifdef VGA_TIMING_VSYNC_IRQ_EN
    begin
      int k;
      chk("irq_low_at_start", 32'(irq), 0);
      k = 0;
      while (!irq && k < 2 * FRAME) begin
        @(negedge clk);
        k++;
      end
      chk("irq_rise_clk", k, VV * LINE);
      repeat (20) @(negedge clk);
      chk("irq_held", 32'(irq), 1);
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
      chk("irq_cleared", 32'(irq), 0);
      repeat (98) @(negedge clk);
      chk("irq_low_before_set", 32'(irq), 0);
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
      chk("irq_set_beats_ack", 32'(irq), 1);
      @(negedge clk);
      chk("irq_still_high", 32'(irq), 1);
    end
`endif

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
